// File: rtl/native2axil_pkg.sv
// Shared definitions for the native-to-AXI4-Lite adapter: FSM encoding,
// AXI response codes and the fixed protection value.
package native2axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_DONE         = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // EXOKAY is accepted as success; only SLVERR/DECERR flag an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/native2axil_adapter.sv
// Converts single-beat native requests into one AXI4-Lite write or read and
// returns completion as a one-cycle native_ready pulse.
module native2axil_adapter
    import native2axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  native_valid,
    input  logic [ADDR_WIDTH-1:0] native_addr,
    input  logic [DATA_WIDTH-1:0] native_wdata,
    input  logic [STRB_WIDTH-1:0] native_wstrb,
    output logic [DATA_WIDTH-1:0] native_rdata,
    output logic                  native_ready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic                  axil_err,
    output state_t                dbg_state
);

    // AXI handshakes: a beat transfers on a rising edge where valid and ready
    // are both high; valid and payload stay stable until then, and this block
    // raises bready/rready only in the states that expect a response.
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic bready_q, bready_d, rready_q, rready_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic ready_q, ready_d, err_q, err_d;
    logic aw_fire, w_fire;

    assign aw_fire = awvalid_q && m_axil_awready;
    assign w_fire  = wvalid_q && m_axil_wready;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ready_d   = 1'b0;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (native_valid) begin
                    addr_d  = native_addr;
                    wdata_d = native_wdata;
                    wstrb_d = native_wstrb;
                    if (|native_wstrb) begin
                        state_d   = ST_WR_ADDR_DATA;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    err_d    = err_q | resp_is_err(m_axil_bresp);
                    ready_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_RD_ADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_axil_rvalid) begin
                    rready_d = 1'b0;
                    rdata_d  = m_axil_rdata;
                    err_d    = err_q | resp_is_err(m_axil_rresp);
                    ready_d  = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            // DONE ignores native_valid so the finished request is not reissued.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign native_rdata   = rdata_q;
    assign native_ready   = ready_q;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = PROT_DEFAULT;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = wstrb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = addr_q;
    assign m_axil_arprot  = PROT_DEFAULT;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;
    assign axil_err       = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_native2axil_adapter.sv
// Directed bench for native2axil_adapter: a negedge-driven AXI4-Lite slave
// with configurable wait states and a small word memory.
module tb_native2axil_adapter;
  import native2axil_pkg::*;

  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        native_valid, native_ready;
  logic [31:0] native_addr, native_wdata, native_rdata;
  logic [3:0]  native_wstrb;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, axil_err;
  logic [1:0]  m_bresp, m_rresp;
  state_t      dbg_state;

  native2axil_adapter dut (
    .clk(clk), .rst(rst),
    .native_valid(native_valid), .native_addr(native_addr),
    .native_wdata(native_wdata), .native_wstrb(native_wstrb),
    .native_rdata(native_rdata), .native_ready(native_ready),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
    .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
    .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready),
    .axil_err(axil_err), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // slave configuration and state
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;
  logic [31:0] mem [0:63];
  int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
  logic aw_got, w_got, b_pend, r_pend;
  logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic [31:0] s_awaddr, s_wdata, s_araddr, merged;
  logic [3:0]  s_wstrb;

  // per-request trace, index = cycles after the request was presented
  logic aw_tr [0:MAXC];
  logic w_tr  [0:MAXC];
  logic ar_tr [0:MAXC];
  logic b_tr  [0:MAXC];
  logic r_tr  [0:MAXC];
  logic nr_tr [0:MAXC];
  int done_k;
  logic [31:0] rd_val;

  task automatic slave_clear();
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
  endtask

  // Slave: the fire flags record handshakes seen on the previous posedge.
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0; merged = 0;
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst) begin
        slave_clear();
      end else begin
        if (aw_fire) begin aw_got = 1; aw_cnt = 0; end
        if (w_fire) begin w_got = 1; w_cnt = 0; end
        if (ar_fire) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; end
        if (b_fire) m_bvalid = 0;
        if (r_fire) m_rvalid = 0;
        if (aw_got && w_got) begin
          merged = mem[s_awaddr[7:2]];
          for (int i = 0; i < 4; i++)
            if (s_wstrb[i]) merged[8*i +: 8] = s_wdata[8*i +: 8];
          mem[s_awaddr[7:2]] = merged;
          aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
        end
        if (m_awvalid && !aw_got) begin
          m_awready = (aw_cnt >= aw_delay);
          aw_cnt++;
          if (m_awready) s_awaddr = m_awaddr;
        end else m_awready = 0;
        if (m_wvalid && !w_got) begin
          m_wready = (w_cnt >= w_delay);
          w_cnt++;
          if (m_wready) begin s_wdata = m_wdata; s_wstrb = m_wstrb; end
        end else m_wready = 0;
        if (m_arvalid && !r_pend && !m_rvalid) begin
          m_arready = (ar_cnt >= ar_delay);
          ar_cnt++;
          if (m_arready) s_araddr = m_araddr;
        end else m_arready = 0;
        if (b_pend) begin
          if (b_cnt >= b_delay) begin m_bvalid = 1; m_bresp = bresp_cfg; b_pend = 0; end
          else b_cnt++;
        end
        if (r_pend) begin
          if (r_cnt >= r_delay) begin
            m_rvalid = 1; m_rdata = mem[s_araddr[7:2]]; m_rresp = rresp_cfg; r_pend = 0;
          end else r_cnt++;
        end
        aw_fire = m_awvalid && m_awready;
        w_fire  = m_wvalid && m_wready;
        ar_fire = m_arvalid && m_arready;
        b_fire  = m_bvalid && m_bready;
        r_fire  = m_rvalid && m_rready;
      end
    end
  end

  // Present one request at the current negedge and trace until native_ready.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    done_k = 0;
    rd_val = 32'h0;
    for (int i = 0; i <= MAXC; i++) begin
      aw_tr[i] = 0; w_tr[i] = 0; ar_tr[i] = 0; b_tr[i] = 0; r_tr[i] = 0; nr_tr[i] = 0;
    end
    native_valid = 1; native_addr = a; native_wdata = d; native_wstrb = s;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      aw_tr[k] = m_awvalid; w_tr[k] = m_wvalid; ar_tr[k] = m_arvalid;
      b_tr[k] = m_bready; r_tr[k] = m_rready; nr_tr[k] = native_ready;
      if (native_ready) begin
        done_k = k;
        rd_val = native_rdata;
        break;
      end
    end
    native_valid = 0;
    if (done_k == 0) begin
      rst = 0;
      repeat (2) @(negedge clk);
      rst = 1;
    end
  endtask

  task automatic test_reset();
    total++; if (m_awvalid !== 1'b0) begin bad++; $display("FAIL reset_awvalid got=%b exp=0", m_awvalid); end
    total++; if (m_wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid got=%b exp=0", m_wvalid); end
    total++; if (m_arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b exp=0", m_arvalid); end
    total++; if ({m_bready, m_rready} !== 2'b00) begin bad++; $display("FAIL reset_readies got=%b exp=00", {m_bready, m_rready}); end
    total++; if (native_ready !== 1'b0) begin bad++; $display("FAIL reset_native_ready got=%b exp=0", native_ready); end
    total++; if (native_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", native_rdata); end
    total++; if (axil_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", axil_err); end
    total++; if (m_awaddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", m_awaddr); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if ({m_awprot, m_arprot} !== 6'b0) begin bad++; $display("FAIL prot got=%b exp=0", {m_awprot, m_arprot}); end
  endtask

  task automatic test_write_min();
    @(negedge clk);
    aw_delay = 0; w_delay = 0; b_delay = 0;
    do_req(32'h10, 32'hDEADBEEF, 4'hF);
    total++; if ({aw_tr[1], w_tr[1]} !== 2'b11) begin bad++; $display("FAIL wmin_valid_c1 got=%b exp=11", {aw_tr[1], w_tr[1]}); end
    total++; if ({aw_tr[2], w_tr[2]} !== 2'b00) begin bad++; $display("FAIL wmin_valid_c2 got=%b exp=00", {aw_tr[2], w_tr[2]}); end
    total++; if (done_k !== 3) begin bad++; $display("FAIL wmin_latency got=%0d exp=3", done_k); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL wmin_mem got=%h exp=deadbeef", mem[4]); end
    @(negedge clk);
    total++; if (native_ready !== 1'b0) begin bad++; $display("FAIL wmin_single_pulse got=%b exp=0", native_ready); end
  endtask

  task automatic test_read_delayed();
    @(negedge clk);
    r_delay = 5;
    do_req(32'h10, 32'h0, 4'h0);
    r_delay = 0;
    total++; if (ar_tr[1] !== 1'b1 || ar_tr[2] !== 1'b0) begin bad++; $display("FAIL rdel_arvalid got=%b%b exp=10", ar_tr[1], ar_tr[2]); end
    total++; if (r_tr[2] !== 1'b1 || r_tr[7] !== 1'b1) begin bad++; $display("FAIL rdel_rready got=%b%b exp=11", r_tr[2], r_tr[7]); end
    total++; if (done_k !== 8) begin bad++; $display("FAIL rdel_latency got=%0d exp=8", done_k); end
    total++; if (rd_val !== 32'hDEADBEEF) begin bad++; $display("FAIL rdel_rdata got=%h exp=deadbeef", rd_val); end
    @(negedge clk);
    total++; if (native_ready !== 1'b0) begin bad++; $display("FAIL rdel_single_pulse got=%b exp=0", native_ready); end
  endtask

  task automatic test_write_stall();
    @(negedge clk);
    aw_delay = 1; w_delay = 5;
    do_req(32'h14, 32'h12345678, 4'hF);
    aw_delay = 0; w_delay = 0;
    total++; if ({aw_tr[2], aw_tr[3]} !== 2'b10) begin bad++; $display("FAIL wst_awvalid got=%b exp=10", {aw_tr[2], aw_tr[3]}); end
    total++; if ({w_tr[2], w_tr[6], w_tr[7]} !== 3'b110) begin bad++; $display("FAIL wst_wvalid got=%b exp=110", {w_tr[2], w_tr[6], w_tr[7]}); end
    total++; if ({b_tr[3], b_tr[6], b_tr[7]} !== 3'b001) begin bad++; $display("FAIL wst_bready got=%b exp=001", {b_tr[3], b_tr[6], b_tr[7]}); end
    total++; if (done_k !== 8) begin bad++; $display("FAIL wst_latency got=%0d exp=8", done_k); end
    total++; if (mem[5] !== 32'h12345678) begin bad++; $display("FAIL wst_mem got=%h exp=12345678", mem[5]); end
    total++; if (native_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_rdata_hold got=%h exp=deadbeef", native_rdata); end
  endtask

  task automatic test_error_sticky();
    @(negedge clk);
    rresp_cfg = RESP_SLVERR;
    do_req(32'h14, 32'h0, 4'h0);
    rresp_cfg = RESP_OKAY;
    total++; if (done_k !== 3) begin bad++; $display("FAIL err_latency got=%0d exp=3", done_k); end
    total++; if (rd_val !== 32'h12345678) begin bad++; $display("FAIL err_rdata got=%h exp=12345678", rd_val); end
    total++; if (axil_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", axil_err); end
    @(negedge clk);
    do_req(32'h18, 32'h0BADF00D, 4'hF);
    @(negedge clk);
    do_req(32'h10, 32'h0, 4'h0);
    total++; if (rd_val !== 32'hDEADBEEF) begin bad++; $display("FAIL err_ok_read got=%h exp=deadbeef", rd_val); end
    total++; if (axil_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", axil_err); end
  endtask

  task automatic test_strobe_back_to_back();
    @(negedge clk);
    do_req(32'h20, 32'hFFFFFFFF, 4'hF);
    total++; if (done_k !== 3) begin bad++; $display("FAIL b2b_first got=%0d exp=3", done_k); end
    do_req(32'h20, 32'h0000ABCD, 4'h3);
    total++; if (done_k !== 4) begin bad++; $display("FAIL b2b_second got=%0d exp=4", done_k); end
    total++; if ({nr_tr[1], aw_tr[1], aw_tr[2]} !== 3'b001) begin bad++; $display("FAIL b2b_accept got=%b exp=001", {nr_tr[1], aw_tr[1], aw_tr[2]}); end
    do_req(32'h20, 32'h0, 4'h0);
    total++; if (done_k !== 4 || nr_tr[1] !== 1'b0) begin bad++; $display("FAIL b2b_third got=%0d/%b exp=4/0", done_k, nr_tr[1]); end
    total++; if (rd_val !== 32'hFFFFABCD) begin bad++; $display("FAIL strobe_merge got=%h exp=ffffabcd", rd_val); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    b_delay = 10;
    native_valid = 1; native_addr = 32'h24; native_wdata = 32'h55; native_wstrb = 4'hF;
    repeat (4) @(negedge clk);
    total++; if (m_bready !== 1'b1) begin bad++; $display("FAIL rmid_in_wr_resp got=%b exp=1", m_bready); end
    rst = 0;
    native_valid = 0;
    #1;
    total++; if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 5'b0) begin bad++; $display("FAIL rmid_drop got=%b exp=00000", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if ({axil_err, native_rdata} !== 33'h0) begin bad++; $display("FAIL rmid_clear got=%b/%h exp=0/0", axil_err, native_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    b_delay = 0;
    @(negedge clk);
    do_req(32'h20, 32'h0, 4'h0);
    total++; if (done_k !== 3) begin bad++; $display("FAIL rmid_read_latency got=%0d exp=3", done_k); end
    total++; if (rd_val !== 32'hFFFFABCD) begin bad++; $display("FAIL rmid_read_data got=%h exp=ffffabcd", rd_val); end
  endtask

  initial begin
    native_valid = 0; native_addr = 0; native_wdata = 0; native_wstrb = 0;
    rst = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1;
    @(negedge clk);
    test_write_min();
    test_read_delayed();
    test_write_stall();
    test_error_sticky();
    test_strobe_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
